// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains bytes from a FIFO one at a time and transmits each as an 8N1 UART frame.
module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_re,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(DATA_WIDTH) + 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, START, DATA, STOP} state_t;

  state_t                state_q, state_d;
  logic [BW-1:0]         baud_q, baud_d;
  logic [CW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0] sr_q, sr_d;
  logic                  tx_q, tx_d, re_q, re_d, busy_q, busy_d, done_q, done_d;
  logic                  bit_end, timed, shift;

  always_comb begin
    bit_end = baud_q == BAUD_LAST;
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (tx_en && !fifo_empty) ? FETCH : IDLE;
      FETCH:   state_d = WAIT;
      WAIT:    state_d = START;
      START:   state_d = bit_end ? DATA : START;
      DATA:    state_d = (bit_end && bit_q == BIT_LAST) ? STOP : DATA;
      STOP:    state_d = bit_end ? IDLE : STOP;
      default: state_d = IDLE;
    endcase
    timed  = state_q inside {START, DATA, STOP};
    shift  = state_q == DATA && bit_end;
    // baud count restarts on every state entry and at every bit boundary
    baud_d = (!timed || state_d != state_q || bit_end) ? '0 : baud_q + 1'b1;
    bit_d  = state_q != DATA ? '0 : shift ? bit_q + 1'b1 : bit_q;
    sr_d   = state_q == WAIT ? fifo_data : shift ? sr_q >> 1 : sr_q;
    tx_d   = state_d == START ? 1'b0 : state_d == DATA ? sr_d[0] : 1'b1;
    re_d   = state_d == FETCH;
    busy_d = !(state_d inside {IDLE, FETCH});
    done_d = state_q == STOP && state_d == IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      tx_q    <= 1'b1;
      re_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      tx_q    <= tx_d;
      re_q    <= re_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign fifo_re = re_q;
  assign tx      = tx_q;
  assign busy    = busy_q;
  assign tx_done = done_q;
endmodule
